// File: rtl/extrema_pattern_gen.sv
// Signed triangle/trapezoid stimulus source with peak/trough marker strobes.
// Optional `NOISE_EN adds saturated LFSR noise on top of the clean ramp.
module extrema_pattern_gen #(
   parameter int data_width  = 12,
   parameter int step_width  = 8,
   parameter int range_width = 10,
   parameter int NOISE_BITS  = 2
) (
   input  logic                         clk_in,
   input  logic                         rst_n,
   input  logic                         enable,
   input  logic signed [data_width-1:0] lo_level,
   input  logic signed [data_width-1:0] hi_level,
   input  logic        [step_width-1:0] step,
   input  logic       [range_width-1:0] hold,
   output logic signed [data_width-1:0] data_out,
   output logic                         peak_pulse,
   output logic                         trough_pulse,
   output logic                         busy
);

   localparam int EW = data_width + 2;

   typedef enum logic [2:0] {IDLE, RISE, HOLD_HI, FALL, HOLD_LO} state_t;

   state_t                         state, state_nxt;
   logic signed [data_width-1:0]   ramp, ramp_nxt;
   logic signed [data_width-1:0]   lo_sh, hi_sh;
   logic        [step_width-1:0]   step_sh;
   logic        [range_width-1:0]  hold_sh;
   logic        [range_width-1:0]  cnt, cnt_nxt;
   logic                           peak_nxt, trough_nxt, load, cfg_ok;
   logic signed [EW-1:0]           up_sum, dn_sum;

   assign cfg_ok = enable && (step != '0) && (hi_level > lo_level);
   assign up_sum = EW'(ramp) + EW'($signed({1'b0, step_sh}));
   assign dn_sum = EW'(ramp) - EW'($signed({1'b0, step_sh}));
   assign busy   = (state != IDLE);

   always_comb begin
      state_nxt  = state;
      ramp_nxt   = ramp;
      cnt_nxt    = cnt;
      peak_nxt   = 1'b0;
      trough_nxt = 1'b0;
      load       = 1'b0;
      case (state)
         IDLE: begin
            if (cfg_ok) begin
               load      = 1'b1;
               ramp_nxt  = lo_level;
               state_nxt = RISE;
            end
         end
         RISE: begin
            if (up_sum >= EW'(hi_sh)) begin
               ramp_nxt = hi_sh;
               peak_nxt = 1'b1;
               if (hold_sh == '0) begin
                  state_nxt = FALL;
               end else begin
                  cnt_nxt   = hold_sh;
                  state_nxt = HOLD_HI;
               end
            end else begin
               ramp_nxt = up_sum[data_width-1:0];
            end
         end
         HOLD_HI: begin
            cnt_nxt = cnt - 1'b1;
            if (cnt == range_width'(1)) state_nxt = FALL;
         end
         FALL: begin
            if (dn_sum <= EW'(lo_sh)) begin
               ramp_nxt   = lo_sh;
               trough_nxt = 1'b1;
               if (hold_sh == '0) begin
                  // zero hold: the reload decision shares the trough cycle
                  load      = cfg_ok;
                  state_nxt = cfg_ok ? RISE : IDLE;
               end else begin
                  cnt_nxt   = hold_sh;
                  state_nxt = HOLD_LO;
               end
            end else begin
               ramp_nxt = dn_sum[data_width-1:0];
            end
         end
         HOLD_LO: begin
            cnt_nxt = cnt - 1'b1;
            if (cnt == range_width'(1)) begin
               load      = cfg_ok;
               state_nxt = cfg_ok ? RISE : IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         ramp         <= '0;
         cnt          <= '0;
         peak_pulse   <= 1'b0;
         trough_pulse <= 1'b0;
         lo_sh        <= '0;
         hi_sh        <= '0;
         step_sh      <= '0;
         hold_sh      <= '0;
      end else begin
         state        <= state_nxt;
         ramp         <= ramp_nxt;
         cnt          <= cnt_nxt;
         peak_pulse   <= peak_nxt;
         trough_pulse <= trough_nxt;
         if (load) begin
            lo_sh   <= lo_level;
            hi_sh   <= hi_level;
            step_sh <= step;
            hold_sh <= hold;
         end
      end
   end

`ifdef NOISE_EN
   localparam logic signed [data_width-1:0] MAXV = {1'b0, {(data_width-1){1'b1}}};
   localparam logic signed [data_width-1:0] MINV = {1'b1, {(data_width-1){1'b0}}};

   logic [15:0]                  lfsr;
   logic signed [NOISE_BITS-1:0] noise;
   logic signed [EW-1:0]         noisy;
   logic signed [data_width-1:0] noisy_sat, data_q;

   assign noise = lfsr[NOISE_BITS-1:0];
   assign noisy = EW'(ramp_nxt) + EW'(noise);

   always_comb begin
      noisy_sat = noisy[data_width-1:0];
      if (noisy > EW'(MAXV)) noisy_sat = MAXV;
      else if (noisy < EW'(MINV)) noisy_sat = MINV;
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         lfsr   <= 16'hACE1;
         data_q <= '0;
      end else begin
         lfsr   <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
         data_q <= noisy_sat;
      end
   end

   assign data_out = data_q;
`else
   assign data_out = ramp;
`endif

endmodule

// File: tb/tb_extrema_pattern_gen.sv
// Directed-vector bench for extrema_pattern_gen (default build, no noise).
module tb_extrema_pattern_gen;

   logic               clk_in = 1'b0;
   logic               rst_n  = 1'b0;
   logic               enable = 1'b0;
   logic signed [11:0] lo_level = '0;
   logic signed [11:0] hi_level = '0;
   logic        [7:0]  step = '0;
   logic        [9:0]  hold = '0;
   logic signed [11:0] data_out;
   logic               peak_pulse, trough_pulse, busy;

   int nvec = 0;
   int nerr = 0;

   typedef struct {
      logic               en;
      logic signed [11:0] lo, hi;
      logic        [7:0]  st;
      logic        [9:0]  hl;
      logic signed [11:0] d;
      logic               pk, tr, bz;
   } vec_t;

   vec_t tbl[$];
   vec_t cur;

   always #5 clk_in = ~clk_in;

   extrema_pattern_gen #(
      .data_width (12),
      .step_width (8),
      .range_width(10),
      .NOISE_BITS (2)
   ) dut (
      .clk_in      (clk_in),
      .rst_n       (rst_n),
      .enable      (enable),
      .lo_level    (lo_level),
      .hi_level    (hi_level),
      .step        (step),
      .hold        (hold),
      .data_out    (data_out),
      .peak_pulse  (peak_pulse),
      .trough_pulse(trough_pulse),
      .busy        (busy)
   );

   task automatic cfg(input logic en, input int lo, input int hi, input int st, input int hl);
      cur.en = en;
      cur.lo = 12'(lo);
      cur.hi = 12'(hi);
      cur.st = 8'(st);
      cur.hl = 10'(hl);
   endtask

   task automatic ex(input int d, input logic pk, input logic tr, input logic bz);
      vec_t v;
      v    = cur;
      v.d  = 12'(d);
      v.pk = pk;
      v.tr = tr;
      v.bz = bz;
      tbl.push_back(v);
   endtask

   task automatic check(input string name, input int d, input logic pk, input logic tr,
                        input logic bz);
      logic signed [11:0] ed;
      ed   = 12'(d);
      nvec = nvec + 1;
      if (data_out !== ed || peak_pulse !== pk || trough_pulse !== tr || busy !== bz) begin
         nerr = nerr + 1;
         $display("FAIL %s: data_out=%0d peak=%b trough=%b busy=%b, expected %0d %b %b %b",
                  name, data_out, peak_pulse, trough_pulse, busy, ed, pk, tr, bz);
      end
   endtask

   task automatic drive(input logic en, input int lo, input int hi, input int st, input int hl);
      @(negedge clk_in);
      enable   = en;
      lo_level = 12'(lo);
      hi_level = 12'(hi);
      step     = 8'(st);
      hold     = 10'(hl);
   endtask

   task automatic tick(input string name, input int d, input logic pk, input logic tr,
                       input logic bz);
      @(posedge clk_in);
      #1;
      check(name, d, pk, tr, bz);
   endtask

   initial begin
      // basic triangle, hold=0, continuous reload
      cfg(1, -4, 6, 3, 0);
      ex(-4, 0, 0, 1); ex(-1, 0, 0, 1); ex(2, 0, 0, 1); ex(5, 0, 0, 1);
      ex(6, 1, 0, 1);  ex(3, 0, 0, 1);  ex(0, 0, 0, 1); ex(-3, 0, 0, 1);
      ex(-4, 0, 1, 1); ex(-1, 0, 0, 1);
      // enable dropped during RISE: finish the cycle, then idle at lo
      cfg(0, -4, 6, 3, 0);
      ex(2, 0, 0, 1);  ex(5, 0, 0, 1);  ex(6, 1, 0, 1); ex(3, 0, 0, 1);
      ex(0, 0, 0, 1);  ex(-3, 0, 0, 1); ex(-4, 0, 1, 0); ex(-4, 0, 0, 0);
      ex(-4, 0, 0, 0);
      // trapezoid with hold=2
      cfg(1, -4, 6, 3, 2);
      ex(-4, 0, 0, 1); ex(-1, 0, 0, 1); ex(2, 0, 0, 1); ex(5, 0, 0, 1);
      ex(6, 1, 0, 1);  ex(6, 0, 0, 1);  ex(6, 0, 0, 1); ex(3, 0, 0, 1);
      ex(0, 0, 0, 1);  ex(-3, 0, 0, 1); ex(-4, 0, 1, 1); ex(-4, 0, 0, 1);
      ex(-4, 0, 0, 1); ex(-1, 0, 0, 1); ex(2, 0, 0, 1);  ex(5, 0, 0, 1);
      ex(6, 1, 0, 1);  ex(6, 0, 0, 1);  ex(6, 0, 0, 1);  ex(3, 0, 0, 1);
      // hi and hold changed mid-FALL: take effect only at the next reload
      cfg(1, -4, 10, 3, 0);
      ex(0, 0, 0, 1);  ex(-3, 0, 0, 1); ex(-4, 0, 1, 1); ex(-4, 0, 0, 1);
      ex(-4, 0, 0, 1); ex(-1, 0, 0, 1); ex(2, 0, 0, 1);  ex(5, 0, 0, 1);
      ex(8, 0, 0, 1);  ex(10, 1, 0, 1); ex(7, 0, 0, 1);  ex(4, 0, 0, 1);
      ex(1, 0, 0, 1);  ex(-2, 0, 0, 1);
      // step=0 presented at the reload point
      cfg(1, -4, 10, 0, 0);
      ex(-4, 0, 1, 0); ex(-4, 0, 0, 0);
      // invalid hi<=lo from IDLE: stays idle, output unchanged
      cfg(1, 5, 5, 3, 0);
      ex(-4, 0, 0, 0); ex(-4, 0, 0, 0);

      rst_n = 1'b0;
      repeat (2) @(posedge clk_in);
      #1;
      check("reset_state", 0, 0, 0, 0);
      @(negedge clk_in);
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         @(negedge clk_in);
         enable   = tbl[i].en;
         lo_level = tbl[i].lo;
         hi_level = tbl[i].hi;
         step     = tbl[i].st;
         hold     = tbl[i].hl;
         @(posedge clk_in);
         #1;
         check($sformatf("vec%0d", i), tbl[i].d, tbl[i].pk, tbl[i].tr, tbl[i].bz);
      end

      // full-scale ramp: clamp at both rails, no wrap
      drive(1, -2048, 2047, 255, 0);
      tick("full_lo", -2048, 0, 0, 1);
      for (int k = 1; k <= 16; k++) tick($sformatf("full_up%0d", k), -2048 + 255 * k, 0, 0, 1);
      tick("full_peak", 2047, 1, 0, 1);
      for (int k = 1; k <= 16; k++) tick($sformatf("full_dn%0d", k), 2047 - 255 * k, 0, 0, 1);
      tick("full_trough", -2048, 0, 1, 1);
      for (int k = 1; k <= 16; k++) tick($sformatf("full_up2_%0d", k), -2048 + 255 * k, 0, 0, 1);
      tick("full_peak2", 2047, 1, 0, 1);

      // asynchronous reset while the peak strobe is high
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset", 0, 0, 0, 0);
      @(negedge clk_in);
      enable = 1'b0;
      tick("reset_held", 0, 0, 0, 0);
      @(negedge clk_in);
      rst_n = 1'b1;
      tick("post_reset_idle", 0, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
